// File: rtl/vid_yuv2rgb.sv
// Purpose: YUV (8-bit luma, 4-bit chroma) to 8-bit RGB conversion with sync/blank alignment.
// Latency: 3 CE-high clock edges from input sample to R/G/B and *_O; one pixel per CE.
// Backpressure: none; CE low freezes every pipeline register. Optional macro VID_YUV2RGB_BLANK_EN forces black during blanking.
module vid_yuv2rgb (
  input  logic       CLK,
  input  logic       RESn,
  input  logic       CE,
  input  logic [7:0] Y,
  input  logic [3:0] U,
  input  logic [3:0] V,
  input  logic       HS,
  input  logic       VS,
  input  logic       HBL,
  input  logic       VBL,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HS_O,
  output logic       VS_O,
  output logic       HBL_O,
  output logic       VBL_O
);

  // Sync/blank bundle order: {HS, VS, HBL, VBL}
  localparam int SB_HBL = 1;
  localparam int SB_VBL = 0;

  // Stage 1 registers
  logic        [7:0]  y1_q;
  logic signed [8:0]  u1_q, v1_q;
  logic        [3:0]  sb1_q;
  logic signed [8:0]  u1_d, v1_d;

  // Stage 2 registers
  logic        [7:0]  y2_q;
  logic signed [18:0] dr2_q, dg2_q, db2_q;
  logic        [3:0]  sb2_q;
  logic signed [18:0] dr2_d, dg2_d, db2_d;

  // Stage 3 registers
  logic        [7:0]  r3_q, g3_q, b3_q;
  logic        [3:0]  sb3_q;
  logic        [7:0]  r3_d, g3_d, b3_d;

  // Channel sums carried at full product width so every bit participates in the clamp
  logic signed [18:0] sum_r, sum_g, sum_b;
  logic signed [18:0] u_ext, v_ext;
  logic signed [4:0]  u_ctr, v_ctr;

  // Saturate a signed sum into 0..255
  function automatic logic [7:0] sat8(input logic signed [18:0] s);
    if (s < 19'sd0)
      sat8 = 8'd0;
    else if (s > 19'sd255)
      sat8 = 8'hFF;
    else
      sat8 = s[7:0];
  endfunction

  // Chroma re-centred around zero and scaled by 16 (range -128..112)
  always_comb begin
    u_ctr = $signed({1'b0, U}) - 5'sd8;
    v_ctr = $signed({1'b0, V}) - 5'sd8;
    u1_d  = {u_ctr, 4'b0000};
    v1_d  = {v_ctr, 4'b0000};
  end

  // Stage 1: capture luma, centred chroma and sync/blank
  always_ff @(posedge CLK) begin
    if (!RESn) begin
      y1_q  <= '0;
      u1_q  <= '0;
      v1_q  <= '0;
      sb1_q <= '0;
    end else if (CE) begin
      y1_q  <= Y;
      u1_q  <= u1_d;
      v1_q  <= v1_d;
      sb1_q <= {HS, VS, HBL, VBL};
    end
  end

  // Colour-difference products; magnitudes stay well inside 19 bits
  always_comb begin
    u_ext = {{10{u1_q[8]}}, u1_q};
    v_ext = {{10{v1_q[8]}}, v1_q};
    dr2_d = v_ext * 19'sd359;
    dg2_d = -(u_ext * 19'sd88) - (v_ext * 19'sd183);
    db2_d = u_ext * 19'sd454;
  end

  // Stage 2: capture luma and per-channel offsets
  always_ff @(posedge CLK) begin
    if (!RESn) begin
      y2_q  <= '0;
      dr2_q <= '0;
      dg2_q <= '0;
      db2_q <= '0;
      sb2_q <= '0;
    end else if (CE) begin
      y2_q  <= y1_q;
      dr2_q <= dr2_d;
      dg2_q <= dg2_d;
      db2_q <= db2_d;
      sb2_q <= sb1_q;
    end
  end

  // Luma plus floored offset (arithmetic shift), then clamp; optional black during blanking
  always_comb begin
    sum_r = $signed({11'b0, y2_q}) + (dr2_q >>> 8);
    sum_g = $signed({11'b0, y2_q}) + (dg2_q >>> 8);
    sum_b = $signed({11'b0, y2_q}) + (db2_q >>> 8);
    r3_d  = sat8(sum_r);
    g3_d  = sat8(sum_g);
    b3_d  = sat8(sum_b);
`ifdef VID_YUV2RGB_BLANK_EN
    if (sb2_q[SB_HBL] || sb2_q[SB_VBL]) begin
      r3_d = 8'd0;
      g3_d = 8'd0;
      b3_d = 8'd0;
    end
`endif
  end

  // Stage 3: registered outputs
  always_ff @(posedge CLK) begin
    if (!RESn) begin
      r3_q  <= '0;
      g3_q  <= '0;
      b3_q  <= '0;
      sb3_q <= '0;
    end else if (CE) begin
      r3_q  <= r3_d;
      g3_q  <= g3_d;
      b3_q  <= b3_d;
      sb3_q <= sb2_q;
    end
  end

  assign R     = r3_q;
  assign G     = g3_q;
  assign B     = b3_q;
  assign HS_O  = sb3_q[3];
  assign VS_O  = sb3_q[2];
  assign HBL_O = sb3_q[SB_HBL];
  assign VBL_O = sb3_q[SB_VBL];

endmodule

// File: tb/tb_vid_yuv2rgb.sv
// Purpose: self-checking bench for vid_yuv2rgb against a pixel-history reference model.
// Latency: expects each output to be the pixel accepted 3 CE-high edges earlier (zero if fewer since reset).
// Backpressure: CE toggled randomly; outputs must hold while CE is low.
module tb_vid_yuv2rgb;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] u;
    logic [3:0] v;
    logic       hs;
    logic       vs;
    logic       hbl;
    logic       vbl;
  } pix_t;

  logic       CLK = 1'b0;
  logic       RESn = 1'b0;
  logic       CE = 1'b0;
  logic [7:0] Y = '0;
  logic [3:0] U = '0;
  logic [3:0] V = '0;
  logic       HS = 1'b0, VS = 1'b0, HBL = 1'b0, VBL = 1'b0;
  logic [7:0] R, G, B;
  logic       HS_O, VS_O, HBL_O, VBL_O;

  logic [27:0] obs;
  logic [27:0] exp_out;
  pix_t        hist[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  vid_yuv2rgb dut (
    .CLK(CLK), .RESn(RESn), .CE(CE),
    .Y(Y), .U(U), .V(V),
    .HS(HS), .VS(VS), .HBL(HBL), .VBL(VBL),
    .R(R), .G(G), .B(B),
    .HS_O(HS_O), .VS_O(VS_O), .HBL_O(HBL_O), .VBL_O(VBL_O)
  );

  always #5 CLK = ~CLK;

  assign obs = {R, G, B, HS_O, VS_O, HBL_O, VBL_O};

  // Floor division by 256 built from truncating division
  function automatic int fdiv256(input int d);
    int q;
    q = d / 256;
    if ((d % 256 != 0) && (d < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp255(input int s);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // Reference conversion of one pixel straight from the colour equations
  function automatic logic [27:0] conv(input pix_t p);
    int u, v, r, g, b;
    u = (int'(p.u) - 8) * 16;
    v = (int'(p.v) - 8) * 16;
    r = clamp255(int'(p.y) + fdiv256(359 * v));
    g = clamp255(int'(p.y) + fdiv256(-(88 * u) - (183 * v)));
    b = clamp255(int'(p.y) + fdiv256(454 * u));
`ifdef VID_YUV2RGB_BLANK_EN
    if (p.hbl || p.vbl) begin
      r = 0; g = 0; b = 0;
    end
`endif
    return {8'(r), 8'(g), 8'(b), p.hs, p.vs, p.hbl, p.vbl};
  endfunction

  function automatic pix_t mkpix(input logic [7:0] y, input logic [3:0] u, input logic [3:0] v,
                                 input logic [3:0] sb);
    pix_t p;
    p.y = y; p.u = u; p.v = v;
    {p.hs, p.vs, p.hbl, p.vbl} = sb;
    return p;
  endfunction

  // Drive one clock cycle, update the model, and leave exp_out ready just after the edge
  task automatic step(input logic rst_n, input logic ce, input pix_t p);
    RESn = rst_n;
    CE   = ce;
    Y = p.y; U = p.u; V = p.v;
    HS = p.hs; VS = p.vs; HBL = p.hbl; VBL = p.vbl;
    @(posedge CLK);
    if (!rst_n) begin
      hist.delete();
    end else if (ce) begin
      hist.push_back(p);
      if (hist.size() > 3) void'(hist.pop_front());
    end
    #1;
    exp_out = (hist.size() >= 3) ? conv(hist[hist.size() - 3]) : 28'h0;
  endtask

  task automatic test_reset();
    pix_t p;
    for (int i = 0; i < 3; i++) begin
      p = mkpix(8'hA5, 4'h3, 4'hC, 4'hF);
      step(1'b0, 1'b1, p);
      tests_run++;
      if (obs !== 28'h0) begin
        tests_failed++;
        $display("FAIL reset_state cycle %0d: got %h want %h", i, obs, 28'h0);
      end
    end
  endtask

  task automatic test_vectors();
    pix_t seq[6];
    seq[0] = mkpix(8'h80, 4'd8, 4'd8, 4'h0);
    seq[1] = mkpix(8'hFF, 4'd8, 4'd15, 4'h0);
    seq[2] = mkpix(8'h00, 4'd0, 4'd8, 4'h0);
    seq[3] = mkpix(8'h10, 4'd15, 4'd0, 4'h0);
    seq[4] = mkpix(8'h40, 4'd4, 4'd12, 4'h0);
    seq[5] = mkpix(8'h00, 4'd8, 4'd8, 4'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, seq[i]);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("FAIL vectors_model step %0d: got %h want %h", i, obs, exp_out);
      end
      if (i == 2) begin
        tests_run++;
        if (obs[27:4] !== 24'h808080) begin
          tests_failed++;
          $display("FAIL vector_grey: got %h want 808080", obs[27:4]);
        end
      end
      if (i == 3) begin
        tests_run++;
        if (obs[27:4] !== 24'hFFAEFF) begin
          tests_failed++;
          $display("FAIL vector_bright_v: got %h want FFAEFF", obs[27:4]);
        end
      end
      if (i == 4) begin
        tests_run++;
        if (obs[27:4] !== 24'h002C00) begin
          tests_failed++;
          $display("FAIL vector_low_u: got %h want 002C00", obs[27:4]);
        end
      end
    end
  endtask

  task automatic test_hs_align();
    pix_t pa, pb, pc, pd, junk;
    pa   = mkpix(8'h30, 4'd12, 4'd5, 4'b1000);
    pb   = mkpix(8'hC0, 4'd2, 4'd10, 4'b0000);
    pc   = mkpix(8'h55, 4'd8, 4'd3, 4'b0000);
    pd   = mkpix(8'h99, 4'd9, 4'd9, 4'b0000);
    junk = mkpix(8'hEE, 4'd1, 4'd14, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: step(1'b1, 1'b1, pa);
        2: step(1'b1, 1'b1, pb);
        4: step(1'b1, 1'b1, pc);
        6: step(1'b1, 1'b1, pd);
        default: step(1'b1, 1'b0, junk);
      endcase
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("FAIL hs_align_model step %0d: got %h want %h", i, obs, exp_out);
      end
      if (i == 4 || i == 5) begin
        tests_run++;
        if (HS_O !== 1'b1 || obs[27:4] !== conv(pa) >> 4) begin
          tests_failed++;
          $display("FAIL hs_align_with_A step %0d: got %h want %h", i, obs, conv(pa));
        end
      end
      if (i == 6) begin
        tests_run++;
        if (HS_O !== 1'b0) begin
          tests_failed++;
          $display("FAIL hs_clear_with_B: got %b want 0", HS_O);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pix_t p;
    for (int i = 0; i < 3; i++) begin
      p = mkpix(8'hF0 - 8'(i), 4'd8, 4'd8, 4'b1111);
      step(1'b1, 1'b1, p);
    end
    p = mkpix(8'h77, 4'd6, 4'd11, 4'b0101);
    step(1'b0, 1'b1, p);
    tests_run++;
    if (obs !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: got %h want 0", obs);
    end
    for (int i = 0; i < 4; i++) begin
      p = mkpix(8'h20 + 8'(i), 4'(i + 5), 4'(10 - i), 4'b0100);
      step(1'b1, 1'b1, p);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("FAIL reset_mid_after step %0d: got %h want %h", i, obs, exp_out);
      end
      if (i < 2) begin
        tests_run++;
        if (obs !== 28'h0) begin
          tests_failed++;
          $display("FAIL reset_mid_no_stale step %0d: got %h want 0", i, obs);
        end
      end
    end
  endtask

  task automatic test_blank();
    pix_t p;
    logic [27:0] want;
`ifdef VID_YUV2RGB_BLANK_EN
    want = {24'h000000, 4'b0010};
`else
    want = {24'hFFFFFF, 4'b0010};
`endif
    step(1'b1, 1'b1, mkpix(8'hFF, 4'd8, 4'd8, 4'b0010));
    step(1'b1, 1'b1, mkpix(8'h11, 4'd8, 4'd8, 4'b0000));
    step(1'b1, 1'b1, mkpix(8'h22, 4'd8, 4'd8, 4'b0000));
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL blank_hbl: got %h want %h", obs, want);
    end
  endtask

  task automatic test_random();
    pix_t p;
    logic rst_n, ce;
    for (int i = 0; i < 400; i++) begin
      p.y = 8'($urandom); p.u = 4'($urandom); p.v = 4'($urandom);
      p.hs = 1'($urandom); p.vs = 1'($urandom);
      p.hbl = ($urandom_range(0, 3) == 0); p.vbl = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      ce    = ($urandom_range(0, 9) < 6);
      step(rst_n, ce, p);
      tests_run++;
      if (obs !== exp_out) begin
        tests_failed++;
        $display("FAIL random step %0d: got %h want %h", i, obs, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hs_align();
    test_reset_mid();
    test_blank();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vid_yuv2rgb.md
VID_YUV2RGB -- requirements
Module: vid_yuv2rgb

Interface
REQ-001 SHALL have no parameters; all coefficients and widths fixed as stated below.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESn  input  1  reset, synchronous, active-low; sampled on rising CLK regardless of CE.
REQ-004 CE  input  1  pixel clock enable; pipeline advances only when high.
REQ-005 Y  input  8  luma, unsigned 0..255.
REQ-006 U  input  4  chroma U, unsigned, centre 8.
REQ-007 V  input  4  chroma V, unsigned, centre 8.
REQ-008 HS, VS  input  1 each  sync, active-high, passed through unmodified in polarity.
REQ-009 HBL, VBL  input  1 each  blanking flags, active-high.
REQ-010 R, G, B  output  8 each  converted colour, unsigned.
REQ-011 HS_O, VS_O, HBL_O, VBL_O  output  1 each  sync/blank delayed to align with R/G/B.

Function
REQ-012 SHALL expand chroma to signed 9-bit: u = (U - 8) << 4, v = (V - 8) << 4; range -128..112.
REQ-013 SHALL compute dR = 359*v, dG = -(88*u) - (183*v), dB = 454*u as signed 19-bit products/sums; no overflow possible.
REQ-014 SHALL form each channel = Y + (d >>> 8), arithmetic shift (floor toward minus infinity), signed 11-bit sum.
REQ-015 SHALL clamp each channel: sum < 0 -> 0; sum > 255 -> 255; else sum[7:0].
REQ-016 Stage 1 (CE cycle n): register Y, u, v, sync/blank; stage 2: register Y and dR/dG/dB; stage 3: register clamped R/G/B.
REQ-017 Latency SHALL be exactly 3 CE-high clock edges from input sample to R/G/B and *_O change.
REQ-018 HS_O, VS_O, HBL_O, VBL_O SHALL traverse a 3-stage delay clocked identically to the colour path, so all outputs describe the same pixel.
REQ-019 With CE low, every pipeline register SHALL hold; outputs remain static for any number of cycles.
REQ-020 Outputs SHALL be registered; no combinational path from any input to any output.
REQ-021 Back-to-back CE-high cycles SHALL accept a new pixel each cycle (throughput 1 pixel per CE).

Reset
REQ-022 On RESn low at a rising CLK edge, all pipeline stages SHALL clear: R=G=B=0, HS_O=VS_O=HBL_O=VBL_O=0.
REQ-023 Reset SHALL take priority over CE; reset asserted mid-stream discards all in-flight pixels.
REQ-024 After RESn deasserts, first valid output SHALL appear on the 3rd CE-high edge; earlier outputs read as zero.

Configuration
REQ-025 Macro VID_YUV2RGB_BLANK_EN SHALL select blank forcing.
REQ-026 Defined: at stage 3, if delayed HBL or VBL is high, R=G=B=0 regardless of Y/U/V.
REQ-027 Undefined: R/G/B SHALL reflect conversion of input values during blanking; blank flags only delayed.
REQ-028 The macro SHALL NOT alter latency, sync alignment or reset values.

Verification
REQ-029 Y=0x80, U=8, V=8, CE held high -> after 3 edges R=G=B=0x80.
REQ-030 Y=0xFF, U=8, V=15 -> R=0xFF (clamped), G=0xAE, B=0xFF.
REQ-031 Y=0x00, U=0, V=8 -> R=0x00, G=0x2C, B=0x00 (B clamped from -227).
REQ-032 Pulse HS for one CE cycle with pixel A, then pixel B; CE toggling 1/0 -> HS_O high exactly with A's colour, held while CE low, cleared with B.
REQ-033 Stream 3 pixels, assert RESn low one cycle with CE high -> all outputs 0 next edge; no pre-reset pixel emerges afterwards.
REQ-034 HBL=1, Y=0xFF, U=V=8 -> with VID_YUV2RGB_BLANK_EN R=G=B=0, HBL_O=1; without, R=G=B=0xFF, HBL_O=1.
